instr_fetch_unit: RTL and testbench

- Fetch stage of the KGPminiRISC multicycle core.
- Holds the PC and runs a request/ready handshake with instruction memory.
- Latches each fetched word into an instruction register and splits it into fields.
- imm16 feeds the signExtender directly; opcode, rs and rt go to control and the register file.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the KGPminiRISC multicycle core: PC, imem handshake, IR and field split.
// Latency: a word accepted at edge N (imem_ready=1 in FETCH) is presented with instr_valid=1 after edge N.
// Backpressure: the presented instruction is held in HOLD while stall=1; memory wait states keep FETCH asserted.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request and byte address (always equals pc)
//   imem_rdata/imem_ready     returned word and its qualifier
//   stall                     downstream cannot consume the presented instruction
//   branch_taken/target       redirect; overrides any same-cycle fetch completion
//   instr_valid/instr/instr_pc latched instruction and the address it came from
//   opcode/rs/rt/imm16        combinational slices of instr
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imm16
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_imem_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over a same-cycle memory return: the word is dropped,
            // instr/instr_pc keep their stale contents but are marked invalid.
            r_pc          <= {branch_target[31:2], 2'b00};
            r_instr_valid <= 1'b0;
            r_state       <= S_FETCH;
            r_imem_req    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_pc          <= r_pc + PC_STEP; // wraps modulo 2^32
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                        r_imem_req    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                    r_imem_req    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[31:26];
    assign rs          = r_instr[25:21];
    assign rt          = r_instr[20:16];
    assign imm16       = r_instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the fetch protocol.
// Two instances run in lockstep, the second with RESET_PC at the top of memory.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic        req_a, vld_a, req_b, vld_b;
    logic [31:0] addr_a, instr_a, ipc_a, addr_b, instr_b, ipc_b;
    logic [5:0]  op_a, op_b;
    logic [4:0]  rs_a, rt_a, rs_b, rt_b;
    logic [15:0] imm_a, imm_b;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] RPC_A = 32'h0000_0000;
    localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC_A), .PC_STEP(32'd4)) dut_a (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(vld_a), .instr(instr_a), .instr_pc(ipc_a),
        .opcode(op_a), .rs(rs_a), .rt(rt_a), .imm16(imm_a)
    );

    instr_fetch_unit #(.RESET_PC(RPC_B), .PC_STEP(32'd4)) dut_b (
        .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(vld_b), .instr(instr_b), .instr_pc(ipc_b),
        .opcode(op_b), .rs(rs_b), .rt(rt_b), .imm16(imm_b)
    );

    // Behavioural model: the unit requests whenever it has finished its
    // post-reset settle cycle and is not holding an instruction.
    logic        m_booting;
    logic        m_holding;
    logic [31:0] m_word;
    logic [31:0] m_pc  [2];
    logic [31:0] m_wpc [2];
    int          captures;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_booting = 1'b1;
            m_holding = 1'b0;
            m_word    = 32'h0;
            m_pc[0]   = RPC_A;
            m_pc[1]   = RPC_B;
            m_wpc[0]  = 32'h0;
            m_wpc[1]  = 32'h0;
        end else if (branch_taken) begin
            m_booting = 1'b0;
            m_holding = 1'b0;
            for (int k = 0; k < 2; k++) m_pc[k] = branch_target & 32'hFFFF_FFFC;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_holding) begin
            if (imem_ready) begin
                m_holding = 1'b1;
                m_word    = imem_rdata;
                captures++;
                for (int k = 0; k < 2; k++) begin
                    m_wpc[k] = m_pc[k];
                    m_pc[k]  = m_pc[k] + 32'd4;
                end
            end
        end else if (!stall) begin
            m_holding = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = !m_booting && !m_holding;
        check_val("req",    {31'h0, req_a}, {31'h0, exp_req});
        check_val("addr",   addr_a, m_pc[0]);
        check_val("valid",  {31'h0, vld_a}, {31'h0, m_holding});
        check_val("instr",  instr_a, m_word);
        check_val("ipc",    ipc_a, m_wpc[0]);
        check_val("opcode", {26'h0, op_a}, {26'h0, m_word[31:26]});
        check_val("rs",     {27'h0, rs_a}, {27'h0, m_word[25:21]});
        check_val("rt",     {27'h0, rt_a}, {27'h0, m_word[20:16]});
        check_val("imm16",  {16'h0, imm_a}, {16'h0, m_word[15:0]});
        check_val("b_req",  {31'h0, req_b}, {31'h0, exp_req});
        check_val("b_addr", addr_b, m_pc[1]);
        check_val("b_ipc",  ipc_b, m_wpc[1]);
        check_val("b_instr", instr_b, m_word);
    endtask

    // Apply inputs (called just after a falling edge), run one rising edge,
    // then compare a little after it and return at the next falling edge.
    task automatic cyc(input logic r, input logic rdy, input logic [31:0] data,
                       input logic stl, input logic br, input logic [31:0] tgt);
        rst           = r;
        imem_ready    = rdy;
        imem_rdata    = data;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    int cap_before;

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        captures = 0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check_val("rst_req",   {31'h0, req_a}, 32'h0);
        check_val("rst_addr",  addr_a, 32'h0);
        check_val("rst_valid", {31'h0, vld_a}, 32'h0);
        check_val("rst_instr", instr_a, 32'h0);
        check_val("rst_addr_b", addr_b, 32'hFFFF_FFFC);

        // IDLE cycle, then FETCH with zero-wait memory
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check_val("idle_no_capture", {31'h0, vld_a}, 32'h0);
        check_val("fetch_req_cycle2", {31'h0, req_a}, 32'h1);
        cyc(0, 1, 32'h2C22_FFF0, 1, 0, 0);
        check_val("cap_valid", {31'h0, vld_a}, 32'h1);
        check_val("cap_ipc",   ipc_a, 32'h0);
        check_val("cap_op",    {26'h0, op_a}, 32'h0B);
        check_val("cap_rs",    {27'h0, rs_a}, 32'h1);
        check_val("cap_rt",    {27'h0, rt_a}, 32'h2);
        check_val("cap_imm",   {16'h0, imm_a}, 32'hFFF0);
        check_val("cap_addr",  addr_a, 32'h4);
        check_val("wrap_addr", addr_b, 32'h0);
        check_val("wrap_ipc",  ipc_b, 32'hFFFF_FFFC);

        // Stall hold for 5 cycles, then release
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'h1111_1111, 1, 0, 0);
        check_val("stall_instr", instr_a, 32'h2C22_FFF0);
        check_val("stall_req",   {31'h0, req_a}, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("release_valid", {31'h0, vld_a}, 32'h0);

        // Three wait states then the word arrives
        cap_before = captures;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'h5555_5555, 0, 0, 0);
            check_val("wait_addr", addr_a, 32'h4);
        end
        cyc(0, 1, 32'h8C41_0008, 0, 0, 0);
        check_val("wait_one_capture", captures - cap_before, 32'h1);
        check_val("wait_pc", addr_a, 32'h8);
        cyc(0, 0, 0, 0, 0, 0);

        // Branch colliding with imem_ready in FETCH
        cyc(0, 1, 32'hFFFF_0000, 0, 1, 32'h0000_0103);
        check_val("br_fetch_valid", {31'h0, vld_a}, 32'h0);
        check_val("br_fetch_addr",  addr_a, 32'h0000_0100);
        check_val("br_fetch_instr", instr_a, 32'h8C41_0008);

        // Capture, then branch while stalled in HOLD
        cyc(0, 1, 32'h0123_4567, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h0000_0200);
        check_val("br_hold_valid", {31'h0, vld_a}, 32'h0);
        check_val("br_hold_addr",  addr_a, 32'h0000_0200);

        // Reset while FETCH waits on memory
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check_val("midrst_addr",  addr_a, 32'h0);
        check_val("midrst_instr", instr_a, 32'h0);
        check_val("midrst_req",   {31'h0, req_a}, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("midrst_idle_req", {31'h0, req_a}, 32'h1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 45),
                $urandom(),
                ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 6),
                $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
